// File: rtl/sim_bus_checker.sv
// ---------------------------------------------------------------------------
// sim_bus_checker
//   Snoops the CPU write bus and acts as a self-checking test monitor.
//   It has three parts:
//   - An exit register. A write to EXIT_ADDR ends the run as pass or fail.
//   - NUM_CH print channels. Each channel checks the values written to it.
//   - A watchdog. It fails the run after TIMEOUT cycles in RUN.
//   All outputs are registered and clear on the asynchronous reset.
//
// Ports
//   i_clk         CPU clock
//   i_rst         asynchronous, active-high reset
//   i_addr        CPU address            [ADDR_W]
//   i_data        CPU write data         [DATA_W]
//   i_we          CPU write enable
//   o_done        run finished (sticky)
//   o_pass        run finished with pass (sticky)
//   o_status      0 run, 1 pass, 2 bad exit code, 3 check violation, 4 timeout
//   o_fail_ch     channel that violated (meaningful when status==3)
//   o_exit_code   value written to EXIT_ADDR
//   o_print_valid one-cycle pulse per channel write event
//   o_print_ch    channel of that event
//   o_print_data  data of that event
//   o_ch_last     last accepted value per channel; channel k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module sim_bus_checker #(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 8,
  parameter int              NUM_CH     = 2,
  parameter logic [ADDR_W-1:0] EXIT_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] CH_BASE   = 16'h0001,
  parameter logic [DATA_W-1:0] PASS_CODE = 8'h6D,
  parameter int              CHECK_MODE = 1,
  parameter int              STEP       = 1,
  parameter int              TIMEOUT    = 5000,
  // A single channel still needs a 1-bit channel field.
  localparam int             CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_we,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [2:0]               o_status,
  output logic [CH_W-1:0]          o_fail_ch,
  output logic [DATA_W-1:0]        o_exit_code,
  output logic                     o_print_valid,
  output logic [CH_W-1:0]          o_print_ch,
  output logic [DATA_W-1:0]        o_print_data,
  output logic [NUM_CH*DATA_W-1:0] o_ch_last
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_BADEXIT = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  CH_SPAN  = (ADDR_W + 1)'(NUM_CH);

  // Decide whether a channel write is accepted, given the last accepted value.
  function automatic logic ch_ok(input logic [DATA_W-1:0] prev,
                                 input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] nxt;
    nxt = prev + DATA_W'(STEP);
    case (CHECK_MODE)
      1:       ch_ok = (data > prev);
      2:       ch_ok = (data == nxt);
      default: ch_ok = 1'b1;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        status_q, status_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CH_W-1:0]   fail_ch_q, fail_ch_d;
  logic [DATA_W-1:0] exit_q, exit_d;
  logic              pv_q, pv_d;
  logic [CH_W-1:0]   pch_q, pch_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic [DATA_W-1:0] last_q [NUM_CH];
  logic [DATA_W-1:0] last_d [NUM_CH];
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              we_prev_q;
  logic [ADDR_W-1:0] addr_prev_q;

  logic              ev;
  logic              in_ch;
  logic [ADDR_W:0]   ch_off;
  logic [CH_W-1:0]   ch_idx;
  logic              terminal;

  // A held write to one address is a single event.
  // A new event needs a rising we or a changed address.
  assign ev     = i_we && (!we_prev_q || (i_addr != addr_prev_q));
  assign ch_off = {1'b0, i_addr} - {1'b0, CH_BASE};
  assign in_ch  = (i_addr >= CH_BASE) && (ch_off < CH_SPAN);
  assign ch_idx = ch_off[CH_W-1:0];

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_ch_d = fail_ch_q;
    exit_d    = exit_q;
    pv_d      = 1'b0;
    pch_d     = pch_q;
    pdata_d   = pdata_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terminal  = 1'b0;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (ev && (i_addr == EXIT_ADDR)) begin
        terminal = 1'b1;
        exit_d   = i_data;
        done_d   = 1'b1;
        if (i_data == PASS_CODE) begin
          state_d  = S_PASS;
          status_d = ST_PASS;
          pass_d   = 1'b1;
        end else begin
          state_d  = S_FAIL;
          status_d = ST_BADEXIT;
        end
      end else if (ev && in_ch) begin
        // A violating write still produces its print pulse.
        pv_d    = 1'b1;
        pch_d   = ch_idx;
        pdata_d = i_data;
        if (ch_ok(last_q[ch_idx], i_data)) begin
          last_d[ch_idx] = i_data;
        end else begin
          terminal  = 1'b1;
          state_d   = S_FAIL;
          status_d  = ST_CHECK;
          fail_ch_d = ch_idx;
          done_d    = 1'b1;
        end
      end
      // A terminal write in the last cycle wins over the watchdog.
      if (!terminal && (cnt_q == TMO_LAST)) begin
        state_d  = S_FAIL;
        status_d = ST_TIMEOUT;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_RUN;
      status_q    <= ST_RUN;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_ch_q   <= '0;
      exit_q      <= '0;
      pv_q        <= 1'b0;
      pch_q       <= '0;
      pdata_q     <= '0;
      last_q      <= '{default: '0};
      cnt_q       <= '0;
      we_prev_q   <= 1'b0;
      addr_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_ch_q   <= fail_ch_d;
      exit_q      <= exit_d;
      pv_q        <= pv_d;
      pch_q       <= pch_d;
      pdata_q     <= pdata_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_prev_q   <= i_we;
      addr_prev_q <= i_addr;
    end
  end

  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_status      = status_q;
  assign o_fail_ch     = fail_ch_q;
  assign o_exit_code   = exit_q;
  assign o_print_valid = pv_q;
  assign o_print_ch    = pch_q;
  assign o_print_data  = pdata_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_last
    assign o_ch_last[k*DATA_W +: DATA_W] = last_q[k];
  end

endmodule
